uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx -- UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined).
//
// Deserialises frames from an asynchronous idle-high serial line. The line is
// double-flopped before use; every bit is sampled near its centre by counting
// half a bit from the start edge and then whole bits. A start bit that is no
// longer low at its centre is dropped as a glitch. A low stop bit (or a parity
// mismatch) is reported on o_Rx_Err instead of o_Rx_DV.
//
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after the data).
//
// Ports:
//   i_Clock      system clock, rising edge
//   i_Rst_n      synchronous reset, active low
//   i_Rx_Serial  asynchronous serial input, idle high
//   o_Rx_DV      one-cycle pulse, o_Rx_Byte holds a new good byte
//   o_Rx_Byte    last good byte, updated only with o_Rx_DV
//   o_Rx_Busy    high from start-bit acceptance until back in IDLE
//   o_Rx_Err     one-cycle pulse on framing (or parity) error
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Busy,
  output logic       o_Rx_Err
);

  localparam logic [12:0] HALF_CNT = 13'((CLKS_PER_BIT - 1) / 2);
  localparam logic [12:0] FULL_CNT = 13'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_CLEANUP
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        rx_s_q, rx_s_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  // Set after a low stop bit: a held-low line (break) must go high before
  // another start bit can be accepted.
  logic        wait_high_q, wait_high_d;
  logic        par_q, par_d;
  logic        frame_ok;

  always_comb begin
    sync1_d     = i_Rx_Serial;
    rx_s_d      = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q + 13'd1;
    idx_d       = idx_q;
    shift_d     = shift_q;
    byte_d      = byte_q;
    dv_d        = 1'b0;
    err_d       = 1'b0;
    busy_d      = busy_q;
    wait_high_d = wait_high_q;
    par_d       = par_q;
    frame_ok    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        busy_d = 1'b0;
        if (rx_s_q)            wait_high_d = 1'b0;
        else if (!wait_high_q) state_d     = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = S_DATA;
            busy_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          par_d   = rx_s_q;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          state_d = S_CLEANUP;
`ifdef UART_RX_PARITY_EN
          frame_ok = rx_s_q && (par_q == ^shift_q);
`else
          frame_ok = rx_s_q;
`endif
          if (frame_ok) begin
            dv_d   = 1'b1;
            byte_d = shift_q;
          end else begin
            err_d = 1'b1;
          end
          if (!rx_s_q) wait_high_d = 1'b1;
        end
      end
      S_CLEANUP: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      byte_q      <= 8'h00;
      dv_q        <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      wait_high_q <= 1'b0;
      par_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      dv_q        <= dv_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      wait_high_q <= wait_high_d;
      par_q       <= par_d;
    end
  end

  assign o_Rx_DV   = dv_q;
  assign o_Rx_Err  = err_q;
  assign o_Rx_Byte = byte_q;
  assign o_Rx_Busy = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx -- scoreboard bench for uart_rx at CLKS_PER_BIT=8.
// Stimulus pushes the expected pulse (DV or Err, byte, start time) per frame;
// a negedge monitor pops and compares whenever o_Rx_DV or o_Rx_Err is high.
module tb_uart_rx;
  localparam int C = 8;
  localparam int H = (C - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NOM = 2 + H + 9 * C + PB * C;

  logic       gclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       dv, err, busy;
  logic [7:0] rbyte;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock    (gclk),
    .i_Rst_n    (rst_n),
    .i_Rx_Serial(rx),
    .o_Rx_DV    (dv),
    .o_Rx_Byte  (rbyte),
    .o_Rx_Busy  (busy),
    .o_Rx_Err   (err)
  );

  always #5 gclk = ~gclk;

  int cyc = 0;
  always @(posedge gclk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] b;
    int         t0;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge gclk) begin : mon
    exp_t e;
    int   lat;
    if (rst_n && (dv || err)) begin
      chk("dv_err_exclusive", int'(dv && err), 0);
      if (sb.size() == 0) begin
        chk("spurious_pulse", {dv, err}, 0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind_err", int'(err), int'(e.is_err));
        chk("rx_byte", int'(rbyte), int'(e.b));
        lat = cyc - e.t0;
        n_chk++;
        if (lat >= NOM - 3 && lat <= NOM + 3) n_pass++;
        else $display("FAIL latency: got %0d cycles expected %0d +/-3", lat, NOM);
      end
    end
  end

  task automatic bit_(input logic b);
    rx = b;
    repeat (C) @(posedge gclk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic par_flip,
                      input bit chk_busy);
    bit good;
`ifdef UART_RX_PARITY_EN
    good = stop && !par_flip;
`else
    good = stop;
`endif
    if (good) last_good = d;
    sb.push_back('{!good, last_good, cyc});
    bit_(1'b0);
    for (int i = 0; i < 8; i++) begin
      bit_(d[i]);
      if (chk_busy && i == 3) chk("busy_mid_frame", int'(busy), 1);
    end
`ifdef UART_RX_PARITY_EN
    bit_((^d) ^ par_flip);
`endif
    bit_(stop);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dv"}, int'(dv), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_byte"}, int'(rbyte), 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge gclk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(posedge gclk);
    #1;

    // Basic frame
    send(8'hA5, 1'b1, 1'b0, 1'b1);
    repeat (2 * C) @(posedge gclk);
    #1;

    // Back-to-back, no idle gap
    send(8'h00, 1'b1, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 1'b0);
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    repeat (2 * C) @(posedge gclk);
    #1;

    // Short low glitch must be dropped at the start-bit centre check
    rx = 1'b0;
    repeat (2) @(posedge gclk);
    #1;
    rx = 1'b1;
    repeat (2 * C) @(posedge gclk);
    #1;
    chk("busy_after_glitch", int'(busy), 0);

    // Framing error followed by a 20-bit break, then recovery
    send(8'h55, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) bit_(1'b0);
    chk("busy_during_break", int'(busy), 0);
    bit_(1'b1);
    bit_(1'b1);
    send(8'h5A, 1'b1, 1'b0, 1'b0);
    repeat (2 * C) @(posedge gclk);
    #1;

    // Reset pulse in the middle of data bit 4 of an 0xFF frame
    bit_(1'b0);
    for (int i = 0; i < 4; i++) bit_(1'b1);
    rx = 1'b1;
    repeat (C / 2) @(posedge gclk);
    #1;
    rst_n = 1'b0;
    @(posedge gclk);
    #1;
    rst_n = 1'b1;
    chk_all_zero("midframe_reset");
    last_good = 8'h00;
    repeat (C - C / 2 - 1) @(posedge gclk);
    #1;
    for (int i = 5; i < 8; i++) bit_(1'b1);
`ifdef UART_RX_PARITY_EN
    bit_(1'b1);
`endif
    bit_(1'b1);
    repeat (2 * C) @(posedge gclk);
    #1;

    send(8'h81, 1'b1, 1'b0, 1'b0);
    repeat (2 * C) @(posedge gclk);
    #1;

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0, 1'b0);
    repeat (2 * C) @(posedge gclk);
    #1;
    send(8'h07, 1'b1, 1'b1, 1'b0);
    repeat (2 * C) @(posedge gclk);
    #1;
`endif

    for (int i = 0; i < 4 * C && sb.size() != 0; i++) @(posedge gclk);
    repeat (2 * C) @(posedge gclk);
    chk("scoreboard_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
